data_ram_slave: RTL and testbench
=================================

// Module: data_ram_slave
// PURPOSE
//  Responder side of the core's data-memory bus (ce/we/addr/sel/data): word-organised SRAM with byte-lane writes.
//  Sits outside the core and feeds read data back to the MEM stage in the same cycle.
//  After reset, a sequential clear sweep runs and raises a stall request to the pipeline ctrl until it finishes.
//  Counts out-of-range accesses for debug.
// PARAMETERS
//  ADDR_W     10           word-address width; DEPTH = 2**ADDR_W words
//  INIT_CLEAR 1            1: zero every word after reset (INIT sweep); 0: go straight to RUN
//  MMIO_ADDR  32'h8000_0000 byte address of the GPIO register (only with DATA_RAM_MMIO_EN)
// PORTS
//  clk         in   1   single clock, all state on posedge
//  rst         in   1   asynchronous, active-low reset
//  ce_i        in   1   access request this cycle
//  we_i        in   1   1 = write, 0 = read (qualified by ce_i)
//  addr_i      in   32  byte address; bits [1:0] ignored
//  sel_i       in   4   byte lanes; big-endian: sel_i[3] -> data[31:24] = byte offset 0
//  data_i      in   32  write data
//  data_o      out  32  read data, combinational
//  stallreq_o  out  1   high while INIT sweep runs
//  err_cnt_o   out  8   saturating count of out-of-range accesses
//  gpio_o      out  32  GPIO register (only with DATA_RAM_MMIO_EN)
// BEHAVIOUR
//  - Reset (rst=0): state = INIT if INIT_CLEAR else RUN; clr_ptr = 0; err_cnt_o = 0; gpio_o = 0; stallreq_o = (INIT_CLEAR).
//    The storage array itself is not reset.
//  - FSM INIT: each cycle writes 0 to word clr_ptr, then clr_ptr++.
//    At clr_ptr == DEPTH-1 the write happens, then INIT->RUN on that edge.
//    INIT lasts exactly DEPTH cycles. stallreq_o = 1, data_o = 0, all bus accesses ignored (no write, no error count).
//  - FSM RUN: terminal state; stallreq_o = 0.
//  - Decode: in range <=> addr_i[31:ADDR_W+2] == 0; word index = addr_i[ADDR_W+1:2].
//  - Read (RUN, ce_i & ~we_i, in range): data_o = array[index], same cycle (0 latency). All 4 lanes always driven; sel_i is ignored on reads.
//  - Write (RUN, ce_i & we_i, in range): at the next posedge, only lanes with sel_i[k]=1 update. sel_i = 0 is a legal no-op.
//    A read of that word in the following cycle returns the new data; no same-cycle bypass.
//  - One access per cycle; we_i selects read or write.
//  - data_o = 0 when ~ce_i, on a write, on out-of-range, or in INIT.
//  - Out-of-range access in RUN (read or write): no array change; data_o = 0; err_cnt_o += 1 at posedge, holding at 8'hFF.
//  - Reset asserted mid-INIT or mid-write: async return to reset values; the sweep restarts from 0; any pending write is lost.
// CONFIGURATION
//  - DATA_RAM_MMIO_EN defined:
//    - Address MMIO_ADDR (word-compare on addr_i[31:2]) hits gpio register, never the array, and does not count as an error.
//    - Writes are byte-laned by sel_i; reads return gpio_o combinationally; gpio_o is registered.
//  - DATA_RAM_MMIO_EN undefined: gpio_o port absent; MMIO_ADDR is ordinary out-of-range (counts as error, reads 0).
// STRUCTURE
//  - Shared package data_bus_pkg holds:
//    - DataBus width 32 and SelBus width 4;
//    - state encoding S_INIT = 1'b0, S_RUN = 1'b1;
//    - ERR_CNT_MAX = 8'hFF and default MMIO_ADDR.
//  - One sub-module data_ram_array (ADDR_W):
//    - DEPTH x 32 storage; async read port; sync write port with 4-bit byte-lane enable.
//    - The FSM, clear pointer, decode, error counter and GPIO stay in data_ram_slave.
// TESTING
//  1. Reset with INIT_CLEAR=1, ADDR_W=4: stallreq_o=1 for exactly 16 cycles after rst rises.
//     Then every word reads 32'h0, including a word preloaded with 32'hDEAD_BEEF.
//  2. RUN: write addr 0x10, sel 4'b1111, data 32'h1122_3344; then write sel 4'b0100, data 32'hAABB_CCDD.
//     A read at 0x10 returns 32'h11BB_3344.
//  3. Write addr 0x14 with sel 4'b0000: contents unchanged, err_cnt_o unchanged.
//     Read with ce_i=0 -> data_o = 0.
//  4. Access addr 0x0000_1000 (ADDR_W=4) 300 times: no array change, data_o = 0, err_cnt_o saturates at 8'hFF.
//  5. Assert rst at INIT cycle 7, release: sweep restarts, stallreq_o high for a full 16 cycles.
//     A bus write issued during INIT is not stored.
//  6. With DATA_RAM_MMIO_EN: write MMIO_ADDR sel 4'b0001 data 32'h0000_005A -> gpio_o = 32'h0000_005A next cycle.
//     Read returns it; err_cnt_o stays 0.
//     Without the macro, the same write increments err_cnt_o by 1.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared definitions for the core data-memory bus: widths, FSM encoding,
// error-counter ceiling and the default GPIO byte address.
package data_bus_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } ram_state_e;

    localparam logic [7:0]  ERR_CNT_MAX   = 8'hFF;
    localparam logic [31:0] MMIO_ADDR_DEF = 32'h8000_0000;

    // Byte-lane merge; lane k covers bits [8k+7:8k], so sel[3] is byte offset 0.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [SEL_W-1:0]  sel
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < SEL_W; k++) begin
            if (sel[k]) begin
                res[k*8 +: 8] = new_word[k*8 +: 8];
            end else begin
                res[k*8 +: 8] = old_word[k*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// DEPTH x 32 storage with an asynchronous read port and a synchronous,
// byte-lane-enabled write port. Contents are intentionally not reset.
module data_ram_array
    import data_bus_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SEL_W-1:0]  wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Per-lane write so each byte maps onto a byte-enable RAM primitive.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < SEL_W; k++) begin
                if (wsel[k]) begin
                    mem_r[waddr][k*8 +: 8] <= wdata[k*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_ram_slave.sv
// Data-memory bus responder: zero-latency reads, byte-laned writes, post-reset
// clear sweep with pipeline stall, saturating out-of-range counter.
// Optional GPIO register at MMIO_ADDR when DATA_RAM_MMIO_EN is defined.
module data_ram_slave
    import data_bus_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          INIT_CLEAR = 1,
    parameter logic [31:0] MMIO_ADDR  = MMIO_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              stallreq_o,
`ifdef DATA_RAM_MMIO_EN
    output logic [DATA_W-1:0] gpio_o,
`endif
    output logic [7:0]        err_cnt_o
);

    ram_state_e        state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic              stall_r;
    logic [7:0]        err_cnt_r;
    logic [DATA_W-1:0] gpio_r;

    logic              run_s;
    logic              acc_s;
    logic              in_range_s;
    logic              mmio_hit_s;
    logic              arr_we_s;
    logic              err_s;
    logic [ADDR_W-1:0] idx_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [SEL_W-1:0]  mem_wsel_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] mem_rdata_s;
    logic              unused_addr_s;

    assign run_s      = (state_r == S_RUN);
    assign acc_s      = run_s & ce_i;
    assign in_range_s = (addr_i[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
    assign idx_s      = addr_i[ADDR_W+1:2];

`ifdef DATA_RAM_MMIO_EN
    assign mmio_hit_s    = (addr_i[31:2] == MMIO_ADDR[31:2]);
    assign unused_addr_s = ^{addr_i[1:0], MMIO_ADDR[1:0]};
`else
    assign mmio_hit_s    = 1'b0;
    assign unused_addr_s = ^{addr_i[1:0], MMIO_ADDR};
`endif

    assign arr_we_s = acc_s & we_i & in_range_s & ~mmio_hit_s;
    assign err_s    = acc_s & ~in_range_s & ~mmio_hit_s;

    // Write-port mux: the clear sweep owns the array while in INIT.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = idx_s;
        mem_wsel_s  = sel_i;
        mem_wdata_s = data_i;
        if (!run_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_ptr_r;
            mem_wsel_s  = 4'hF;
            mem_wdata_s = 32'h0000_0000;
        end else begin
            mem_we_s    = arr_we_s;
        end
    end

    data_ram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wsel  (mem_wsel_s),
        .wdata (mem_wdata_s),
        .raddr (idx_s),
        .rdata (mem_rdata_s)
    );

    // Combinational read mux; anything other than a valid RUN read yields zero.
    always_comb begin
        data_o = 32'h0000_0000;
        if (acc_s && !we_i) begin
            if (mmio_hit_s) begin
                data_o = gpio_r;
            end else if (in_range_s) begin
                data_o = mem_rdata_s;
            end else begin
                data_o = 32'h0000_0000;
            end
        end else begin
            data_o = 32'h0000_0000;
        end
    end

    // Clear-sweep FSM; stall is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
            stall_r   <= (INIT_CLEAR != 0);
            clr_ptr_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                S_INIT: begin
                    clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (clr_ptr_r == {ADDR_W{1'b1}}) begin
                        state_r <= S_RUN;
                        stall_r <= 1'b0;
                    end else begin
                        state_r <= S_INIT;
                        stall_r <= 1'b1;
                    end
                end
                S_RUN: begin
                    state_r <= S_RUN;
                    stall_r <= 1'b0;
                end
                default: begin
                    state_r <= S_RUN;
                    stall_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating out-of-range access counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_r <= 8'h00;
        end else if (err_s && (err_cnt_r != ERR_CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    // GPIO register, byte-laned like the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_r <= 32'h0000_0000;
        end else if (acc_s && we_i && mmio_hit_s) begin
            gpio_r <= lane_merge(gpio_r, data_i, sel_i);
        end else begin
            gpio_r <= gpio_r;
        end
    end

    assign stallreq_o = stall_r;
    assign err_cnt_o  = err_cnt_r;
`ifdef DATA_RAM_MMIO_EN
    assign gpio_o     = gpio_r;
`endif

endmodule

// File: tb/tb_data_ram_slave.sv
// Scoreboard bench for data_ram_slave (ADDR_W=4, INIT_CLEAR=1); the driver queues
// expectations tagged with a cycle number, a negedge monitor pops and compares them.
module tb_data_ram_slave;

    localparam int K_DATA  = 0;
    localparam int K_STALL = 1;
    localparam int K_ERR   = 2;
    localparam int K_GPIO  = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stallreq_o;
    logic [7:0]  err_cnt_o;
`ifdef DATA_RAM_MMIO_EN
    logic [31:0] gpio_o;
`endif

    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t sb_q[$];
    logic [31:0] mem_model [16];
    int   err_model;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    data_ram_slave #(
        .ADDR_W     (4),
        .INIT_CLEAR (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .sel_i      (sel_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .stallreq_o (stallreq_o),
`ifdef DATA_RAM_MMIO_EN
        .gpio_o     (gpio_o),
`endif
        .err_cnt_o  (err_cnt_o)
    );

    task automatic expect_now(input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc_cnt;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        ce_i   = ce;
        we_i   = we;
        addr_i = a;
        sel_i  = s;
        data_i = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Sweep after rst release: stall high for 16 cycles, bus traffic ignored.
    task automatic run_sweep();
        for (int i = 0; i < 16; i++) begin
            expect_now(K_STALL, 32'h1, "sweep_stall_hi");
            if (i == 3) begin
                drive(1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0);
                expect_now(K_DATA, 32'h0, "init_read_zero");
            end else if (i == 5) begin
                drive(1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF);
            end else if (i == 13) begin
                drive(1'b1, 1'b1, 32'h0000_000C, 4'hF, 32'h1234_5678);
            end else begin
                idle();
            end
            step();
        end
        idle();
        expect_now(K_STALL, 32'h0, "sweep_stall_lo");
        expect_now(K_ERR, 32'h0, "init_no_err");
    endtask

    task automatic read_all(input string nm);
        for (int w = 0; w < 16; w++) begin
            drive(1'b1, 1'b0, 32'(w * 4), 4'h0, 32'h0);
            expect_now(K_DATA, mem_model[w], nm);
            step();
        end
        idle();
    endtask

    // Monitor: compare every expectation due by this cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
                e = sb_q.pop_front();
                case (e.kind)
                    K_DATA:  act = data_o;
                    K_STALL: act = {31'h0, stallreq_o};
                    K_ERR:   act = {24'h0, err_cnt_o};
`ifdef DATA_RAM_MMIO_EN
                    K_GPIO:  act = gpio_o;
`endif
                    default: act = 32'hXXXX_XXXX;
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, e.cyc, act, e.val);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle();
        for (int w = 0; w < 16; w++) mem_model[w] = 32'h0;
        err_model = 0;
        step();
        expect_now(K_STALL, 32'h1, "reset_stall");
        expect_now(K_ERR, 32'h0, "reset_err");
        expect_now(K_DATA, 32'h0, "reset_data");
        step();

        // First sweep, then preload a word that a later sweep must clear.
        rst = 1'b1;
        run_sweep();
        drive(1'b1, 1'b1, 32'h0000_0008, 4'hF, 32'hDEAD_BEEF);
        step();
        drive(1'b1, 1'b0, 32'h0000_0008, 4'h0, 32'h0);
        expect_now(K_DATA, 32'hDEAD_BEEF, "preload_read");
        step();

        // Reset, then abort the sweep at INIT cycle 7 and let it restart.
        rst = 1'b0;
        idle();
        step();
        rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            expect_now(K_STALL, 32'h1, "abort_stall_hi");
            step();
        end
        rst = 1'b0;
        step();
        expect_now(K_STALL, 32'h1, "midinit_reset_stall");
        rst = 1'b1;
        run_sweep();
        read_all("cleared_word");

        // Byte-lane merge.
        drive(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344);
        expect_now(K_DATA, 32'h0, "write_data_zero");
        step();
        drive(1'b1, 1'b1, 32'h0000_0010, 4'b0100, 32'hAABB_CCDD);
        step();
        drive(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        expect_now(K_DATA, 32'h11BB_3344, "lane_merge");
        mem_model[4] = 32'h11BB_3344;
        step();

        // sel=0 write is a no-op; ce=0 reads zero.
        drive(1'b1, 1'b1, 32'h0000_0014, 4'hF, 32'h5566_7788);
        step();
        drive(1'b1, 1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF);
        step();
        drive(1'b1, 1'b0, 32'h0000_0014, 4'h0, 32'h0);
        expect_now(K_DATA, 32'h5566_7788, "sel0_noop");
        expect_now(K_ERR, 32'h0, "sel0_no_err");
        mem_model[5] = 32'h5566_7788;
        step();
        drive(1'b0, 1'b0, 32'h0000_0014, 4'hF, 32'h0);
        expect_now(K_DATA, 32'h0, "ce0_zero");
        step();

        // GPIO address: register hit with the macro, error without.
        drive(1'b1, 1'b1, 32'h8000_0000, 4'b0001, 32'h0000_005A);
        step();
        drive(1'b1, 1'b0, 32'h8000_0000, 4'h0, 32'h0);
`ifdef DATA_RAM_MMIO_EN
        expect_now(K_GPIO, 32'h0000_005A, "gpio_write");
        expect_now(K_DATA, 32'h0000_005A, "gpio_read");
        expect_now(K_ERR, 32'h0, "gpio_no_err");
`else
        expect_now(K_DATA, 32'h0, "mmio_off_read");
        expect_now(K_ERR, 32'h1, "mmio_off_err");
        err_model = 1;
`endif
        step();
`ifndef DATA_RAM_MMIO_EN
        err_model = 2;
`endif
        idle();

        // 300 out-of-range accesses: counter saturates, array untouched.
        for (int i = 0; i < 300; i++) begin
            expect_now(K_ERR, 32'(err_model), "oor_err_cnt");
            if (i % 2 == 0) begin
                drive(1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF);
            end else begin
                drive(1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
                expect_now(K_DATA, 32'h0, "oor_read_zero");
            end
            step();
            if (err_model < 255) err_model++;
        end
        idle();
        expect_now(K_ERR, 32'h0000_00FF, "err_saturated");
        step();
        read_all("post_oor_word");

        step();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
